// File: rtl/nios_sysid_checker.sv
// rtl/nios_sysid_checker.sv - boot-time Avalon-MM system-ID reader and checker
// Reads sysid words 0 and 1, compares them with build-time values and reports pass/error.
module nios_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd37,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1603647235,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  error,
  output logic [31:0] id_word,
  output logic [31:0] ts_word
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state_q;
  logic        read_q;
  logic        addr_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [1:0]  error_q;
  logic [31:0] id_q;
  logic [31:0] ts_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  logic accept;
  logic stall;
  logic timeout_hit;
  logic run_req;

  assign accept      = read_q & ~avm_waitrequest;
  assign stall       = read_q & avm_waitrequest;
  assign cnt_d       = cnt_q + 16'd1;
  // Abort on the stalled cycle that brings the count up to the limit.
  assign timeout_hit = stall && (cnt_d == TIMEOUT_LIM);
  assign run_req     = ((state_q == S_IDLE) && (AUTO_START || start)) ||
                       ((state_q == S_DONE) && start);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      error_q <= 2'd0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
      cnt_q   <= 16'd0;
    end else if (run_req) begin
      state_q <= S_RD_ID;
      read_q  <= 1'b1;
      addr_q  <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      error_q <= 2'd0;
      id_q    <= 32'd0;
      ts_q    <= 32'd0;
      cnt_q   <= 16'd0;
    end else if (timeout_hit) begin
      state_q <= S_DONE;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b1;
      pass_q  <= 1'b0;
      error_q <= 2'd3;
      cnt_q   <= 16'd0;
    end else begin
      case (state_q)
        S_RD_ID: begin
          if (accept) begin
            id_q    <= avm_readdata;
            addr_q  <= 1'b1;
            cnt_q   <= 16'd0;
            state_q <= S_RD_TS;
          end else if (stall) begin
            cnt_q <= cnt_d;
          end
        end
        S_RD_TS: begin
          if (accept) begin
            ts_q    <= avm_readdata;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            cnt_q   <= 16'd0;
            state_q <= S_CHECK;
          end else if (stall) begin
            cnt_q <= cnt_d;
          end
        end
        S_CHECK: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          // ID mismatch outranks timestamp mismatch.
          if (id_q != EXPECTED_ID) begin
            error_q <= 2'd1;
          end else if (ts_q != EXPECTED_TIMESTAMP) begin
            error_q <= 2'd2;
          end else begin
            error_q <= 2'd0;
            pass_q  <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign error       = error_q;
  assign id_word     = id_q;
  assign ts_word     = ts_q;

endmodule

// File: tb/tb_nios_sysid_checker.sv
// tb/tb_nios_sysid_checker.sv - scoreboard bench for nios_sysid_checker
module tb_nios_sysid_checker;

  localparam logic [31:0] EID = 32'd37;
  localparam logic [31:0] ETS = 32'd1603647235;
  localparam int          TO  = 4;

  typedef struct {
    logic        pass;
    logic [1:0]  err;
    logic [31:0] id;
    logic [31:0] ts;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t qa[$];
  exp_t qb[$];

  // DUT A: auto-start, short timeout, configurable stalling slave
  logic        rst_a = 1'b0;
  logic        start_a = 1'b0;
  logic        a_addr, a_read, a_wait, a_busy, a_done, a_pass;
  logic [1:0]  a_err;
  logic [31:0] a_rdata, a_id, a_ts;
  logic [31:0] cfg_id = EID;
  logic [31:0] cfg_ts = ETS;
  int          cfg_s0 = 0;
  int          cfg_s1 = 0;
  int          scnt = 0;

  always @(posedge clock) begin
    if (a_read && a_wait) scnt <= scnt + 1;
    else scnt <= 0;
  end
  assign a_wait  = a_read && (scnt < (a_addr ? cfg_s1 : cfg_s0));
  assign a_rdata = a_addr ? cfg_ts : cfg_id;

  nios_sysid_checker #(.TIMEOUT_CYCLES(TO), .AUTO_START(1'b1)) u_a (
    .clock(clock), .reset_n(rst_a), .start(start_a),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_wait),
    .avm_readdata(a_rdata), .busy(a_busy), .done(a_done), .pass(a_pass),
    .error(a_err), .id_word(a_id), .ts_word(a_ts));

  // DUT B: manual start, zero-wait slave returning the expected words
  logic        rst_b = 1'b0;
  logic        start_b = 1'b0;
  logic        b_addr, b_read, b_busy, b_done, b_pass;
  logic [1:0]  b_err;
  logic [31:0] b_rdata, b_id, b_ts;
  assign b_rdata = b_addr ? ETS : EID;

  nios_sysid_checker #(.AUTO_START(1'b0)) u_b (
    .clock(clock), .reset_n(rst_b), .start(start_b),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(1'b0),
    .avm_readdata(b_rdata), .busy(b_busy), .done(b_done), .pass(b_pass),
    .error(b_err), .id_word(b_id), .ts_word(b_ts));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: result and completion edge from the slave behaviour, c0 = launch edge.
  function automatic exp_t model(logic [31:0] id, logic [31:0] ts, int s0, int s1, int c0);
    exp_t e;
    e.id = 32'd0; e.ts = 32'd0; e.pass = 1'b0; e.err = 2'd0;
    if (s0 >= TO) begin
      e.err = 2'd3;
      e.cyc = c0 + 1 + TO;
    end else if (s1 >= TO) begin
      e.id  = id;
      e.err = 2'd3;
      e.cyc = c0 + 2 + s0 + TO;
    end else begin
      e.id  = id;
      e.ts  = ts;
      if (id != EID) e.err = 2'd1;
      else if (ts != ETS) e.err = 2'd2;
      e.pass = (e.err == 2'd0);
      e.cyc  = c0 + 4 + s0 + s1;
    end
    return e;
  endfunction

  task automatic cmp(string t, exp_t e, logic p, logic [1:0] er, logic [31:0] id,
                     logic [31:0] ts, logic bz);
    chk({t, "_cycle"}, 32'(cyc), 32'(e.cyc));
    chk({t, "_pass"}, 32'(p), 32'(e.pass));
    chk({t, "_error"}, 32'(er), 32'(e.err));
    chk({t, "_id_word"}, id, e.id);
    chk({t, "_ts_word"}, ts, e.ts);
    chk({t, "_busy"}, 32'(bz), 32'd0);
  endtask

  // Monitor A
  initial begin
    logic pd, pstall, paddr;
    exp_t e;
    pd = 1'b0; pstall = 1'b0; paddr = 1'b0;
    forever begin
      @(negedge clock);
      if (rst_a) begin
        if (a_done && !pd) begin
          if (qa.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL a_unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
          end else begin
            e = qa.pop_front();
            cmp("a", e, a_pass, a_err, a_id, a_ts, a_busy);
          end
        end
        if (pstall && a_read) chk("a_addr_hold", 32'(a_addr), 32'(paddr));
        if (pstall && !a_read) chk("a_drop_error", 32'(a_err), 32'd3);
      end
      pd = a_done; pstall = a_read && a_wait; paddr = a_addr;
    end
  end

  // Monitor B
  initial begin
    logic pd;
    exp_t e;
    pd = 1'b0;
    forever begin
      @(negedge clock);
      if (rst_b && b_done && !pd) begin
        if (qb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
        end else begin
          e = qb.pop_front();
          cmp("b", e, b_pass, b_err, b_id, b_ts, b_busy);
        end
      end
      pd = b_done;
    end
  end

  task automatic wait_a(int budget);
    for (int i = 0; i < budget && qa.size() != 0; i++) @(posedge clock);
    if (qa.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL a_wait_done: got no done within %0d cycles expected done", budget);
      qa.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_b(int budget);
    for (int i = 0; i < budget && qb.size() != 0; i++) @(posedge clock);
    if (qb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL b_wait_done: got no done within %0d cycles expected done", budget);
      qb.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic run_a(logic [31:0] id, logic [31:0] ts, int s0, int s1);
    cfg_id = id; cfg_ts = ts; cfg_s0 = s0; cfg_s1 = s1;
    @(posedge clock); #1;
    start_a = 1'b1;
    qa.push_back(model(id, ts, s0, s1, cyc));
    @(posedge clock); #1;
    start_a = 1'b0;
    chk("a_rerun_done_clear", 32'(a_done), 32'd0);
    chk("a_rerun_busy", 32'(a_busy), 32'd1);
    wait_a(100);
  endtask

  logic [31:0] d_id [8] = '{32'd38, EID, 32'd99, EID, EID, EID, EID, EID};
  logic [31:0] d_ts [8] = '{ETS, 32'd0, 32'd5, ETS, ETS, ETS, ETS, ETS};
  int          d_s0 [8] = '{0, 0, 0, 3, 3, 1000, 0, TO - 1};
  int          d_s1 [8] = '{0, 0, 0, 2, 3, 0, 1000, TO};

  initial begin
    logic [31:0] rid, rts;
    // DUT A: reset state, auto-start, directed then random runs
    @(posedge clock); @(posedge clock); #1;
    chk("a_reset_read", 32'(a_read), 32'd0);
    chk("a_reset_busy", 32'(a_busy), 32'd0);
    chk("a_reset_done", 32'(a_done), 32'd0);
    chk("a_reset_error", 32'(a_err), 32'd0);
    @(posedge clock); #1;
    rst_a = 1'b1;
    qa.push_back(model(EID, ETS, 0, 0, cyc));
    wait_a(100);
    for (int i = 0; i < 8; i++) run_a(d_id[i], d_ts[i], d_s0[i], d_s1[i]);
    for (int i = 0; i < 24; i++) begin
      rid = ($urandom_range(0, 2) == 0) ? $urandom : EID;
      rts = ($urandom_range(0, 2) == 0) ? $urandom : ETS;
      run_a(rid, rts, $urandom_range(0, TO + 1), $urandom_range(0, TO + 1));
    end

    // DUT A: reset during the timestamp stall
    cfg_id = EID; cfg_ts = ETS; cfg_s0 = 0; cfg_s1 = 1000;
    @(posedge clock); #1; start_a = 1'b1;
    @(posedge clock); #1; start_a = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    chk("a_stall_read", 32'(a_read), 32'd1);
    chk("a_stall_addr", 32'(a_addr), 32'd1);
    #2 rst_a = 1'b0;
    #1;
    chk("a_async_read", 32'(a_read), 32'd0);
    chk("a_async_addr", 32'(a_addr), 32'd0);
    chk("a_async_busy", 32'(a_busy), 32'd0);
    chk("a_async_id", a_id, 32'd0);
    cfg_s1 = 0;
    @(posedge clock); @(posedge clock); #1;
    rst_a = 1'b1;
    qa.push_back(model(EID, ETS, 0, 0, cyc));
    wait_a(100);

    // DUT B: no auto run, manual start, ignored start while busy, re-run
    rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("b_idle_read", 32'(b_read), 32'd0);
      chk("b_idle_busy", 32'(b_busy), 32'd0);
    end
    start_b = 1'b1;
    qb.push_back(model(EID, ETS, 0, 0, cyc));
    @(posedge clock); #1; start_b = 1'b0;
    @(posedge clock); #1; start_b = 1'b1;
    @(posedge clock); @(posedge clock); #1; start_b = 1'b0;
    wait_b(50);
    repeat (4) @(posedge clock);
    #1;
    chk("b_held_done", 32'(b_done), 32'd1);
    start_b = 1'b1;
    qb.push_back(model(EID, ETS, 0, 0, cyc));
    @(posedge clock); #1; start_b = 1'b0;
    chk("b_rerun_done_clear", 32'(b_done), 32'd0);
    wait_b(50);

    repeat (3) @(posedge clock);
    #1;
    chk("a_queue_empty", 32'(qa.size()), 32'd0);
    chk("b_queue_empty", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule

// File: doc/nios_sysid_checker.md
# nios_sysid_checker

Boot-time system-ID verifier for the Nios Qsys system. It acts as an Avalon-MM read master on the system-ID slave, reading the ID word (address 0) and the timestamp word (address 1). It compares both against build-time expected values and reports pass/fail with an error code, so board logic can hold peripherals off until the loaded FPGA image matches the software build. It runs automatically after reset and can be re-run on a `start` pulse.

## Interface
Parameters:
- EXPECTED_ID, 37, expected value of word 0
- EXPECTED_TIMESTAMP, 1603647235, expected value of word 1
- TIMEOUT_CYCLES, 255, max consecutive cycles a read may be stalled by waitrequest; range 1..65535
- AUTO_START, 1, 1 = start a check automatically after reset release; 0 = wait for `start`

Ports:
- clock  in  1  single system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run a check; ignored while busy
- avm_address  out  1  sysid word select (0 = ID, 1 = timestamp)
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; read accepted and readdata valid in the cycle where avm_read=1 and avm_waitrequest=0
- avm_readdata  in  32  slave read data
- busy  out  1  check in progress
- done  out  1  result valid; held until next check starts or reset
- pass  out  1  1 = both words matched (valid when done=1)
- error  out  2  0 none, 1 ID mismatch, 2 timestamp mismatch, 3 timeout
- id_word  out  32  captured word 0
- ts_word  out  32  captured word 1

## Operation
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- Reset (async): state IDLE; avm_read=0, avm_address=0, busy=0, done=0, pass=0, error=0, id_word=0, ts_word=0, timeout counter=0.
- IDLE:
  - with AUTO_START=1, the first clock after reset release moves to RD_ID;
  - otherwise, start=1 moves to RD_ID.
- Entering RD_ID from IDLE or DONE: done, pass and error clear; id_word and ts_word clear; busy=1.
- RD_ID: avm_read=1, avm_address=0. On accept, capture id_word and go to RD_TS.
- RD_TS: avm_read=1, avm_address=1. On accept, capture ts_word and go to CHECK.
- CHECK (1 cycle): avm_read=0. Compute the result, register pass/error, and go to DONE.
  - error = 1 if id_word ≠ EXPECTED_ID.
  - else error = 2 if ts_word ≠ EXPECTED_TIMESTAMP.
  - else error = 0 and pass = 1.
  - When both words mismatch, error = 1 (ID has priority).
- DONE: done=1, busy=0. start=1 moves to RD_ID (re-run). Outputs are otherwise held indefinitely.
- Timeout:
  - The counter increments each cycle avm_read=1 and avm_waitrequest=1, and resets to 0 on accept and on every state change.
  - When the counter equals TIMEOUT_CYCLES while still stalled, drop avm_read on the next cycle, set error=3 and pass=0, and go to DONE.
  - The word not yet read stays 0.
- Ignored inputs: start while busy; start in IDLE when AUTO_START=1 and the automatic run has already begun.
- Comparisons are full 32-bit equality; no masking.

## Timing
- Zero-wait slave: reset release before edge 0.
  - Edge 1: RD_ID, read address 0 presented.
  - Edge 2: id_word captured; RD_TS, address 1 presented.
  - Edge 3: ts_word captured; CHECK.
  - Edge 4: DONE, with done/pass/error valid together.
  - Total: 4 cycles from start (or reset release) to done.
- Each waitrequest cycle adds exactly one cycle of latency.
- Re-run start in DONE: done drops on the next edge, and the new result appears 4 cycles after the start edge.
- avm_address and avm_read are registered and stable while avm_waitrequest=1.
- Reset asserted mid-read: avm_read deasserts immediately (async). After release, the check restarts per AUTO_START.

## Test plan
- AUTO_START=1, slave returns 37 / 1603647235, no waitrequest -> done=1, pass=1, error=0 exactly 4 cycles after reset release; id_word=37, ts_word=1603647235.
- Slave ID returns 38 (timestamp correct) -> done=1, pass=0, error=1. Repeat with timestamp 0 and ID 37 -> error=2. Repeat with both wrong -> error=1.
- Waitrequest high 3 cycles on word 0 and 2 cycles on word 1 -> address/read held stable while stalled; done at cycle 9; pass=1.
- TIMEOUT_CYCLES=4, waitrequest stuck high -> read dropped after 4 stalled cycles; error=3, pass=0, id_word=0, ts_word=0.
- AUTO_START=0: no read after reset. start pulse -> check completes in 4 cycles. A second start pulse while busy is ignored. start in DONE clears done next cycle and re-runs.
- Assert reset_n low during RD_TS stall -> all outputs 0 asynchronously. After release, a fresh check completes with pass=1.
